// File: rtl/fft_frame_sched.sv
// Frame scheduler for the pipelined FFT butterfly chain: block indexing, per-stage enables, drain and done.
// Optional frame counter output enabled by defining FFT_FRAME_CNT_EN.
module fft_frame_sched #(
    parameter int BLK_PER_FRAME = 32,
    parameter int NUM_STG       = 3,
    parameter int STG_LAT       = 2,
    parameter int IDX_W         = $clog2(BLK_PER_FRAME)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [IDX_W-1:0]   in_idx,
    output logic [NUM_STG-1:0] stg_en,
    output logic               frame_start,
    output logic               frame_done,
    output logic               err_drop
`ifdef FFT_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int DEPTH = NUM_STG * STG_LAT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               accept_s;
    logic               last_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    // pipe_v_r carries every accepted block; pipe_d_r only the frame's last block
    logic [DEPTH-1:0]   pipe_v_r;
    logic [DEPTH-1:0]   pipe_d_r;
    logic [DEPTH-1:0]   pipe_v_s;
    logic [DEPTH-1:0]   pipe_d_s;
    logic               frame_start_r;
    logic               err_drop_r;
    logic               in_ready_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state, accept decision and block index update
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        idx_s    = idx_r;
        if (flush) begin
            state_s = IDLE;
            idx_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, RUN: begin
                    if (din_valid) begin
                        accept_s = 1'b1;
                        last_s   = (idx_r == LAST_IDX);
                        if (last_s) begin
                            idx_s   = {IDX_W{1'b0}};
                            state_s = DRAIN;
                        end else begin
                            idx_s   = idx_r + IDX_W'(1);
                            state_s = RUN;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                DRAIN: begin
                    // frame_done is high this cycle exactly when the last block leaves the final stage
                    if (pipe_d_r[DEPTH-1]) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Delay line shift: new accept enters at bit 0, flush empties it
    always_comb begin
        pipe_v_s = {DEPTH{1'b0}};
        pipe_d_s = {DEPTH{1'b0}};
        if (flush) begin
            pipe_v_s = {DEPTH{1'b0}};
            pipe_d_s = {DEPTH{1'b0}};
        end else begin
            pipe_v_s = (pipe_v_r << 1) | DEPTH'(accept_s);
            pipe_d_s = (pipe_d_r << 1) | DEPTH'(accept_s & last_s);
        end
    end

    // Datapath registers: index, delay line and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r         <= {IDX_W{1'b0}};
            pipe_v_r      <= {DEPTH{1'b0}};
            pipe_d_r      <= {DEPTH{1'b0}};
            frame_start_r <= 1'b0;
            err_drop_r    <= 1'b0;
            in_ready_r    <= 1'b1;
        end else begin
            idx_r         <= idx_s;
            pipe_v_r      <= pipe_v_s;
            pipe_d_r      <= pipe_d_s;
            frame_start_r <= accept_s & (idx_r == {IDX_W{1'b0}});
            in_ready_r    <= (state_s != DRAIN);
            if (flush) begin
                err_drop_r <= 1'b0;
            end else begin
                err_drop_r <= err_drop_r | (din_valid & ~in_ready_r);
            end
        end
    end

    // Stage k sees a block (k+1)*STG_LAT cycles after its accept
    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
        assign stg_en[k] = pipe_v_r[(k+1)*STG_LAT-1];
    end

    assign in_ready    = in_ready_r;
    assign in_idx      = idx_r;
    assign frame_start = frame_start_r;
    assign frame_done  = pipe_d_r[DEPTH-1];
    assign err_drop    = err_drop_r;

`ifdef FFT_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter; aborted frames never produce frame_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (pipe_d_r[DEPTH-1]) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: directed and random input sequences against an accept-history model.
// Covers the optional FFT_FRAME_CNT_EN counter when that macro is defined.
module tb_fft_frame_sched;

    localparam int B  = 32;
    localparam int NS = 3;
    localparam int L  = 2;
    localparam int D  = NS * L;
    localparam int HN = 4096;

    logic          clk;
    logic          rst;
    logic          din_valid;
    logic          in_ready;
    logic          flush;
    logic [4:0]    in_idx;
    logic [NS-1:0] stg_en;
    logic          frame_start;
    logic          frame_done;
    logic          err_drop;
`ifdef FFT_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    fft_frame_sched #(
        .BLK_PER_FRAME(B),
        .NUM_STG(NS),
        .STG_LAT(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din_valid(din_valid),
        .in_ready(in_ready),
        .flush(flush),
        .in_idx(in_idx),
        .stg_en(stg_en),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .err_drop(err_drop)
`ifdef FFT_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: history of accepts by cycle plus frame bookkeeping
    bit acc [HN];
    bit lst [HN];
    bit fst [HN];
    int t      = 0;
    int floor_c = -1;
    int m_cnt  = 0;
    bit m_drain = 1'b0;
    bit m_err  = 1'b0;
    int m_fcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic bit hist(input int a, input bit want_last, input bit want_first);
        if (a < 0 || a <= floor_c || a >= HN) return 1'b0;
        if (!acc[a]) return 1'b0;
        if (want_last && !lst[a]) return 1'b0;
        if (want_first && !fst[a]) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: check outputs at the negedge, update the model, drive inputs
    task automatic step(input logic v, input logic f);
        logic [NS-1:0] e_stg;
        bit            e_done;
        bit            e_ready;
        @(negedge clk);
        e_ready = !m_drain;
        e_done  = hist(t - D, 1'b1, 1'b0);
        for (int k = 0; k < NS; k++) e_stg[k] = hist(t - (k + 1) * L, 1'b0, 1'b0);
        chk("in_ready", in_ready, e_ready);
        chk("in_idx", in_idx, m_cnt);
        chk("stg_en", stg_en, e_stg);
        chk("frame_start", frame_start, hist(t - 1, 1'b0, 1'b1));
        chk("frame_done", frame_done, e_done);
        chk("err_drop", err_drop, m_err);
`ifdef FFT_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, m_fcnt);
`endif
        if (f) begin
            m_cnt   = 0;
            m_drain = 1'b0;
            m_err   = 1'b0;
            floor_c = t;
        end else begin
            if (v && !e_ready) m_err = 1'b1;
            if (v && e_ready) begin
                acc[t] = 1'b1;
                lst[t] = (m_cnt == B - 1);
                fst[t] = (m_cnt == 0);
                if (m_cnt == B - 1) begin
                    m_cnt   = 0;
                    m_drain = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (e_done) m_drain = 1'b0;
        end
        if (e_done) m_fcnt = (m_fcnt + 1) % 65536;
        din_valid = v;
        flush     = f;
        t++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready, 1'b1);
        chk({tag, "_idx"}, in_idx, 5'd0);
        chk({tag, "_stg"}, stg_en, 3'd0);
        chk({tag, "_start"}, frame_start, 1'b0);
        chk({tag, "_done"}, frame_done, 1'b0);
        chk({tag, "_err"}, err_drop, 1'b0);
`ifdef FFT_FRAME_CNT_EN
        chk({tag, "_fcnt"}, frame_cnt, 16'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full frame of back-to-back blocks starting at cycle 0
        repeat (B) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);

        // Blocks on alternate cycles
        repeat (B) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (12) step(1'b0, 1'b0);

        // din_valid held through DRAIN: rejected blocks set the sticky flag
        repeat (B + D + 6) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);

        // Flush after 10 accepts, then a flush with din_valid high, then a clean frame
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        repeat (B) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);

        // Random traffic with occasional flushes
        repeat (400) step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 63) == 0));
        repeat (12) step(1'b0, 1'b0);

        // Asynchronous reset in the middle of DRAIN
        repeat (B) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        m_cnt   = 0;
        m_drain = 1'b0;
        m_err   = 1'b0;
        m_fcnt  = 0;
        floor_c = t;
        t++;
        @(negedge clk);
        rst = 1'b0;
        t++;
        repeat (10) step(1'b0, 1'b0);

        // Three frames with the second one aborted by flush
        repeat (B) step(1'b1, 1'b0);
        repeat (D) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (B) step(1'b1, 1'b0);
        repeat (D + 4) step(1'b0, 1'b0);
`ifdef FFT_FRAME_CNT_EN
        @(negedge clk);
        chk("frame_cnt_final", frame_cnt, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
